// File: rtl/mem_channel_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_channel_responder
// Purpose  : Memory-side responder for the multi-channel valid/ready
//            read/write protocol. Owns a 2**ADDR_BITS x DATA_BITS word array
//            and serves NUM_CHANNELS independent request channels, each with
//            its own IDLE/WAIT/RESPOND FSM and a programmable response
//            latency. A backdoor load port preloads the array before start.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1                       rising-edge clock
//   reset          in   1                       asynchronous, active-low reset
//   read_valid     in   NUM_CHANNELS            per-channel read request
//   read_address   in   NUM_CHANNELS*ADDR_BITS  channel c at [c*ADDR_BITS +: ADDR_BITS]
//   read_ready     out  NUM_CHANNELS            read data valid / request done
//   read_data      out  NUM_CHANNELS*DATA_BITS  per-channel read data
//   write_valid    in   NUM_CHANNELS            per-channel write request
//   write_address  in   NUM_CHANNELS*ADDR_BITS  per-channel write address
//   write_data     in   NUM_CHANNELS*DATA_BITS  per-channel write data
//   write_ready    out  NUM_CHANNELS            write committed / request done
//   load_enable    in   1                       backdoor write strobe
//   load_address   in   ADDR_BITS               backdoor address
//   load_data      in   DATA_BITS               backdoor data
// ----------------------------------------------------------------------------
// Build option
//   MEM_RAND_LATENCY_EN : when defined, each channel draws its latency from a
//                         16-bit Galois LFSR, giving 1..LATENCY cycles per
//                         request. When undefined the latency is fixed.
// ============================================================================
module mem_channel_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address,
    output logic [NUM_CHANNELS-1:0]           read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] read_data,
    input  logic [NUM_CHANNELS-1:0]           write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] write_data,
    output logic [NUM_CHANNELS-1:0]           write_ready,
    input  logic                              load_enable,
    input  logic [ADDR_BITS-1:0]              load_address,
    input  logic [DATA_BITS-1:0]              load_data
);

    localparam int                 DEPTH      = 1 << ADDR_BITS;
    localparam int                 CNT_BITS   = 4;
    localparam logic [CNT_BITS-1:0] LOAD_COUNT = CNT_BITS'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // The 4-bit latency counter only covers 1..15.
    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
        $error("mem_channel_responder: LATENCY=%0d outside legal range 1..15", LATENCY);
    end

    // ------------------------------------------------------------------------
    // Storage array and per-channel commit requests
    // ------------------------------------------------------------------------
    logic [DATA_BITS-1:0]              mem [DEPTH];
    logic [NUM_CHANNELS-1:0]           commit_write;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] commit_address;
    logic [NUM_CHANNELS*DATA_BITS-1:0] commit_data;

    // Write priority is set by statement order: the backdoor load goes first,
    // then channels in ascending index, so the last (highest-index) writer to
    // an address on a given edge is the one that lands. Read captures in the
    // channel blocks sample mem before these updates, so a same-edge read
    // sees the pre-write / pre-load value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (load_enable) begin
                mem[load_address] <= load_data;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (commit_write[c]) begin
                    mem[commit_address[c*ADDR_BITS +: ADDR_BITS]] <=
                        commit_data[c*DATA_BITS +: DATA_BITS];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel request FSMs
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_channel
        state_t               state;
        state_t               state_next;
        logic                 op_write;
        logic                 op_write_next;
        logic [ADDR_BITS-1:0] address;
        logic [ADDR_BITS-1:0] address_next;
        logic [DATA_BITS-1:0] wdata;
        logic [DATA_BITS-1:0] wdata_next;
        logic [CNT_BITS-1:0]  count;
        logic [CNT_BITS-1:0]  count_next;
        logic [CNT_BITS-1:0]  accept_count;
        logic [DATA_BITS-1:0] rdata;
        logic                 rd_req;
        logic                 wr_req;
        logic                 finish;

        assign rd_req = read_valid[c];
        assign wr_req = write_valid[c];

        // The edge that leaves WAIT is also the edge that touches the array.
        assign finish = (state == ST_WAIT) && (count == '0);

`ifdef MEM_RAND_LATENCY_EN
        localparam logic [15:0] LFSR_SEED = 16'hACE1 + 16'(c);

        logic [15:0] lfsr;
        logic [15:0] lfsr_step;
        logic        accept;

        // Right-shifting Galois form of the x^16+x^14+x^13+x^11+1 polynomial.
        assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
        assign accept    = (state == ST_IDLE) && (rd_req || wr_req);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                lfsr <= LFSR_SEED;
            end else if (accept) begin
                lfsr <= lfsr_step;
            end
        end

        // Counter load of (lfsr mod LATENCY) yields an effective latency of
        // 1..LATENCY cycles, using the value present on the accepting edge.
        assign accept_count = CNT_BITS'(lfsr % 16'(LATENCY));
`else
        assign accept_count = LOAD_COUNT;
`endif

        always_comb begin
            state_next    = state;
            op_write_next = op_write;
            address_next  = address;
            wdata_next    = wdata;
            count_next    = count;
            case (state)
                ST_IDLE: begin
                    // Read has priority; a concurrent write simply stays
                    // pending and is taken once the channel is back in IDLE.
                    if (rd_req) begin
                        op_write_next = 1'b0;
                        address_next  = read_address[c*ADDR_BITS +: ADDR_BITS];
                        count_next    = accept_count;
                        state_next    = ST_WAIT;
                    end else if (wr_req) begin
                        op_write_next = 1'b1;
                        address_next  = write_address[c*ADDR_BITS +: ADDR_BITS];
                        wdata_next    = write_data[c*DATA_BITS +: DATA_BITS];
                        count_next    = accept_count;
                        state_next    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (count == '0) begin
                        state_next = ST_RESPOND;
                    end else begin
                        count_next = count - 1'b1;
                    end
                end
                ST_RESPOND: begin
                    // Hold ready until the initiator withdraws its request.
                    if (op_write ? !wr_req : !rd_req) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state    <= ST_IDLE;
                op_write <= 1'b0;
                address  <= '0;
                wdata    <= '0;
                count    <= '0;
            end else begin
                state    <= state_next;
                op_write <= op_write_next;
                address  <= address_next;
                wdata    <= wdata_next;
                count    <= count_next;
            end
        end

        // Read data is only updated by a completing read, so it stays stable
        // after ready falls until the next read on this channel.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rdata <= '0;
            end else if (finish && !op_write) begin
                rdata <= mem[address];
            end
        end

        assign commit_write[c]                             = finish && op_write;
        assign commit_address[c*ADDR_BITS +: ADDR_BITS]    = address;
        assign commit_data[c*DATA_BITS +: DATA_BITS]       = wdata;

        // Ready is decoded straight from the state register so an
        // asynchronous reset drops it immediately.
        assign read_ready[c]                               = (state == ST_RESPOND) && !op_write;
        assign write_ready[c]                              = (state == ST_RESPOND) && op_write;
        assign read_data[c*DATA_BITS +: DATA_BITS]         = rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_channel_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_channel_responder
// Purpose  : Self-checking bench for mem_channel_responder. A table of
//            multi-channel request vectors (with hand-derived expected read
//            data) is applied in a loop; read expectations go into a
//            scoreboard queue when the request is driven and are popped when
//            the channel raises read_ready. Hand-written sequences cover the
//            read-over-write priority and reset during WAIT.
//            With MEM_RAND_LATENCY_EN defined the table holds 100 random
//            ch0 reads and latency is checked against 1..LATENCY.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_channel_responder;

    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int NCH = 4;
`ifdef MEM_RAND_LATENCY_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NCH-1:0]    read_valid = '0;
    logic [NCH*AB-1:0] read_address = '0;
    logic [NCH-1:0]    read_ready;
    logic [NCH*DB-1:0] read_data;
    logic [NCH-1:0]    write_valid = '0;
    logic [NCH*AB-1:0] write_address = '0;
    logic [NCH*DB-1:0] write_data = '0;
    logic [NCH-1:0]    write_ready;
    logic              load_enable = 1'b0;
    logic [AB-1:0]     load_address = '0;
    logic [DB-1:0]     load_data = '0;

    always #5 clk = ~clk;

    mem_channel_responder #(
        .ADDR_BITS   (AB),
        .DATA_BITS   (DB),
        .NUM_CHANNELS(NCH),
        .LATENCY     (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .read_valid   (read_valid),
        .read_address (read_address),
        .read_ready   (read_ready),
        .read_data    (read_data),
        .write_valid  (write_valid),
        .write_address(write_address),
        .write_data   (write_data),
        .write_ready  (write_ready),
        .load_enable  (load_enable),
        .load_address (load_address),
        .load_data    (load_data)
    );

    // pre: 0 none, 1 single backdoor load (ld_addr/ld_data),
    //      2 preload every address with its own value, 3 preload addr^8'h5A
    typedef struct packed {
        logic [3:0]  en;
        logic [3:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [1:0]  pre;
        logic [7:0]  ld_addr;
        logic [7:0]  ld_data;
    } vec_t;

    typedef struct {
        int         ch;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [3:0] en, input logic [3:0] wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rd, input logic [1:0] pre,
                                input logic [7:0] ld_addr, input logic [7:0] ld_data);
        vec_t v;
        v.en = en; v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rd = exp_rd;
        v.pre = pre; v.ld_addr = ld_addr; v.ld_data = ld_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_latency(input string name, input int lat);
`ifdef MEM_RAND_LATENCY_EN
        check(name, 32'((lat >= 1) && (lat <= LAT)), 32'd1);
`else
        check(name, 32'(lat), 32'(LAT));
`endif
    endtask

    // Pop the oldest scoreboard entry for channel c and compare read data.
    task automatic pop_check(input int c, input string name);
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].ch == c) idx = i;
        end
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL %s ch%0d read_ready with no expected entry actual=1 required=0", name, c);
        end else begin
            check($sformatf("%s_ch%0d", name, c), 32'(read_data[c*DB +: DB]), 32'(sb[idx].data));
            sb.delete(idx);
        end
    endtask

    task automatic load_one(input logic [7:0] a, input logic [7:0] d);
        load_enable  = 1'b1;
        load_address = a;
        load_data    = d;
        @(negedge clk);
        load_enable  = 1'b0;
    endtask

    task automatic preload(input logic [7:0] mask);
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            load_one(a, a ^ mask);
        end
    endtask

    // Called on a negedge with all channels idle.
    task automatic run_vec(input vec_t v, input string name);
        logic [3:0] done;
        logic       rdy;
        int         n;
        exp_t       e;
        for (int c = 0; c < NCH; c++) begin
            if (v.en[c]) begin
                if (v.wr[c]) begin
                    write_valid[c]              = 1'b1;
                    write_address[c*AB +: AB]   = v.addr[c*8 +: 8];
                    write_data[c*DB +: DB]      = v.wdata[c*8 +: 8];
                end else begin
                    read_valid[c]               = 1'b1;
                    read_address[c*AB +: AB]    = v.addr[c*8 +: 8];
                    e.ch   = c;
                    e.data = v.exp_rd[c*8 +: 8];
                    sb.push_back(e);
                end
            end
        end
        done = ~v.en;
        n    = 0;
        // First posedge accepts; a ready seen at the n-th negedge arrived
        // n-1 cycles after the accepting edge.
        while (done != 4'hF && n < LAT + 4) begin
            @(negedge clk);
            n++;
            for (int c = 0; c < NCH; c++) begin
                if (!done[c]) begin
                    rdy = v.wr[c] ? write_ready[c] : read_ready[c];
                    if (rdy) begin
                        done[c] = 1'b1;
                        check_latency($sformatf("%s_lat_ch%0d", name, c), n - 1);
                        if (!v.wr[c]) pop_check(c, $sformatf("%s_rdata", name));
                    end
                end
            end
        end
        check($sformatf("%s_all_ready", name), 32'(done), 32'hF);
        read_valid  = '0;
        write_valid = '0;
        @(negedge clk);
        check($sformatf("%s_ready_drop", name), {24'h0, read_ready, write_ready}, 32'h0);
        for (int c = 0; c < NCH; c++) begin
            if (v.en[c] && !v.wr[c]) begin
                check($sformatf("%s_hold_ch%0d", name, c),
                      32'(read_data[c*DB +: DB]), 32'(v.exp_rd[c*8 +: 8]));
            end
        end
    endtask

    task automatic wait_ready(input int c, input bit wr, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wr ? write_ready[c] : read_ready[c]) && n < LAT + 6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   n;
        logic [7:0] ra;

        // ---------------- table ----------------
`ifdef MEM_RAND_LATENCY_EN
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom_range(0, 255));
            vecs.push_back(mk(4'b0001, 4'b0000, {24'h0, ra}, 32'h0,
                              {24'h0, ra ^ 8'h5A}, (i == 0) ? 2'd3 : 2'd0, 8'h0, 8'h0));
        end
`else
        vecs.push_back(mk(4'b0001, 4'b0000, 32'h00000055, 32'h0,        32'h00000000, 2'd0, 8'h00, 8'h00));
        vecs.push_back(mk(4'b0001, 4'b0001, 32'h00000010, 32'h0000005A, 32'h00000000, 2'd0, 8'h00, 8'h00));
        vecs.push_back(mk(4'b0001, 4'b0000, 32'h00000010, 32'h0,        32'h0000005A, 2'd0, 8'h00, 8'h00));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h20202020, 32'h04030201, 32'h00000000, 2'd0, 8'h00, 8'h00));
        vecs.push_back(mk(4'b1001, 4'b0000, 32'h20000020, 32'h0,        32'h04000004, 2'd0, 8'h00, 8'h00));
        vecs.push_back(mk(4'b0110, 4'b0100, 32'h00303000, 32'h00BB0000, 32'h0000AA00, 2'd1, 8'h30, 8'hAA));
        vecs.push_back(mk(4'b0001, 4'b0000, 32'h00000030, 32'h0,        32'h000000BB, 2'd0, 8'h00, 8'h00));
        vecs.push_back(mk(4'b1111, 4'b0000, 32'hFF807F00, 32'h0,        32'hFF807F00, 2'd2, 8'h00, 8'h00));
`endif

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        check("reset_held_ready", {24'h0, read_ready, write_ready}, 32'h0);
        check("reset_held_rdata", read_data, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_rel_ready", {24'h0, read_ready, write_ready}, 32'h0);
        check("reset_rel_rdata", read_data, 32'h0);

        // ---------------- table loop ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].pre == 2'd1) load_one(vecs[i].ld_addr, vecs[i].ld_data);
            if (vecs[i].pre == 2'd2) preload(8'h00);
            if (vecs[i].pre == 2'd3) preload(8'h5A);
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

`ifndef MEM_RAND_LATENCY_EN
        // ------- read and write valid together on ch0: read wins -------
        read_valid[0]      = 1'b1;
        read_address[7:0]  = 8'h50;
        write_valid[0]     = 1'b1;
        write_address[7:0] = 8'h50;
        write_data[7:0]    = 8'h77;
        begin
            exp_t e;
            e.ch = 0; e.data = 8'h50;
            sb.push_back(e);
        end
        wait_ready(0, 1'b0, n);
        check("dual_rd_lat", 32'(n - 1), 32'(LAT));
        check("dual_wr_pending", 32'(write_ready[0]), 32'h0);
        if (read_ready[0]) pop_check(0, "dual_rdata");
        read_valid[0] = 1'b0;
        // one edge back to IDLE, one edge to accept the write, then LAT
        wait_ready(0, 1'b1, n);
        check("dual_wr_lat", 32'(n), 32'(LAT + 2));
        check("dual_rd_low", 32'(read_ready[0]), 32'h0);
        write_valid[0] = 1'b0;
        @(negedge clk);
        check("dual_wr_drop", 32'(write_ready[0]), 32'h0);
        run_vec(mk(4'b0001, 4'b0000, 32'h00000050, 32'h0, 32'h00000077, 2'd0, 8'h0, 8'h0), "dual_after");

        // ------- reset while ch0 is in WAIT on a write -------
        write_valid[0]     = 1'b1;
        write_address[7:0] = 8'h40;
        write_data[7:0]    = 8'hCC;
        @(negedge clk);
        reset          = 1'b0;
        write_valid[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst_wait_ready%0d", k), 32'(write_ready[0]), 32'h0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("rst_wait_after", {24'h0, read_ready, write_ready}, 32'h0);
        run_vec(mk(4'b0001, 4'b0000, 32'h00000040, 32'h0, 32'h00000000, 2'd0, 8'h0, 8'h0), "rst_rd40");
`endif

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_channel_responder.md
Name: mem_channel_responder

Overview:
- Memory-side end of the multi-channel valid/ready read/write channel protocol that the GPU top level and its memory controllers drive as initiator.
- Owns a word-addressed storage array and services NUM_CHANNELS independent request channels.
- Each channel has its own FSM and a programmable response latency.
- Used as the data-memory and program-memory responder in simulation and FPGA builds; a backdoor load port preloads programs and data before start.

Parameters:
ADDR_BITS, 8, address width; array depth = 2**ADDR_BITS words
DATA_BITS, 8, word width
NUM_CHANNELS, 4, independent request channels
LATENCY, 2, cycles from request acceptance to ready; legal range 1..15

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
read_valid  input  NUM_CHANNELS  per-channel read request
read_address  input  NUM_CHANNELS*ADDR_BITS  channel c at bits [c*ADDR_BITS +: ADDR_BITS]
read_ready  output  NUM_CHANNELS  read data valid / request done
read_data  output  NUM_CHANNELS*DATA_BITS  per-channel read data
write_valid  input  NUM_CHANNELS  per-channel write request
write_address  input  NUM_CHANNELS*ADDR_BITS  per-channel write address
write_data  input  NUM_CHANNELS*DATA_BITS  per-channel write data
write_ready  output  NUM_CHANNELS  write committed / request done
load_enable  input  1  backdoor write strobe
load_address  input  ADDR_BITS  backdoor address
load_data  input  DATA_BITS  backdoor data

Behaviour:
- Reset (reset low, asynchronous assertion):
  - read_ready, write_ready and read_data all go to 0.
  - Every channel FSM goes to IDLE and all latency counters clear.
  - Array contents are cleared to 0.
  - Reset mid-transaction abandons the request with no commit; ready drops immediately.
- Per-channel FSM states: IDLE, WAIT, RESPOND.
- IDLE:
  - On an edge where read_valid[c]=1: latch address, op=READ, counter=LATENCY-1, go to WAIT.
  - Else on an edge where write_valid[c]=1: latch address and data, op=WRITE, same counter load, go to WAIT.
  - If read and write are both valid, the read wins; the write stays pending and is accepted once the channel returns to IDLE.
- WAIT:
  - Counter decrements each edge.
  - On the edge where counter==0: go to RESPOND.
  - On that same edge, a WRITE commits to the array and a READ captures array[addr] into read_data slice c.
  - Requests are never re-sampled in WAIT; the latched address and data are used.
- RESPOND:
  - read_ready[c] or write_ready[c] (per op) is held high.
  - On an edge where the matching valid is sampled low: ready drops and the FSM goes to IDLE.
  - read_data holds its value after ready falls, until the next read completes on that channel.
- Timing:
  - Ready rises exactly LATENCY cycles after the accepting edge.
  - Minimum back-to-back period per channel is LATENCY+2 cycles with a one-cycle valid drop.
- Collisions on the same edge:
  - Multiple channels committing writes to the same address: highest channel index wins.
  - A read capture and a write commit to the same address: the read returns the pre-write value.
  - A backdoor load on the same edge as a channel write to the same address: the channel write wins.
  - A backdoor load on the same edge as a read capture: the read sees the pre-load value.
- Address arithmetic: no wrap logic is needed; the full ADDR_BITS range is valid.
- LATENCY outside 1..15 is an elaboration error, enforced with a generate-time $error.

Optional Feature:
- Macro: MEM_RAND_LATENCY_EN.
- Defined:
  - A 16-bit Galois LFSR per channel (taps 16,14,13,11; seed 16'hACE1 plus channel index, reloaded on reset) advances on every accept.
  - Effective latency = (lfsr mod LATENCY)+1, giving a range of 1..LATENCY.
  - All ordering and collision rules are unchanged.
- Undefined: latency is fixed at LATENCY and the LFSR logic is absent.

Test Plan:
- Reset then idle: hold reset low 3 cycles and release. Required: all ready and read_data bits 0, and a read of any address returns 8'h00.
- Single write then read on ch0, LATENCY=2: write addr 8'h10 data 8'h5A; write_ready[0] rises 2 cycles after accept; drop valid and ready falls next cycle. Then read 8'h10: read_ready[0] rises 2 cycles after accept with read_data slice 0 = 8'h5A.
- All 4 channels write addr 8'h20 on the same edge with data 8'h01..8'h04. A subsequent read returns 8'h04.
- Same-edge collision: ch1 reads 8'h30 (preloaded 8'hAA) while ch2 writes 8'h30=8'hBB. Required: ch1 gets 8'hAA; a later read gets 8'hBB.
- Backdoor preload of addrs 0..255 with value = addr, then 4-channel concurrent reads of 8'h00, 8'h7F, 8'h80, 8'hFF. Required: each channel returns its own address value and the channels are independent.
- Reset asserted while ch0 is in WAIT on a write of 8'h40=8'hCC. Required: ready never rises, and after release a read of 8'h40 returns 8'h00.
- With MEM_RAND_LATENCY_EN defined, LATENCY=4: 100 reads on ch0. Required: every ready arrives 1..4 cycles after accept and the data is correct.
